// File: rtl/btn_conditioner.sv
// Five-button debouncer: 2-flop synchronizers, one-hot press/release FSMs, single-cycle SCEN pulses.
// Define BTN_AUTO_REPEAT_EN to add hold-to-repeat pulses on BtnR and BtnD.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 15000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnC,
  output logic       BtnL_SCEN,
  output logic       BtnR_SCEN,
  output logic       BtnU_SCEN,
  output logic       BtnD_SCEN,
  output logic       BtnC_SCEN,
  output logic [4:0] Btn_DPB
);

  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [4:0]    REPEAT_MASK = 5'b01010;  // R and D only
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST   = CW'(REPEAT_RATE - 1);
`endif

  typedef enum logic [5:0] {
    ARM  = 6'b000001,
    INI  = 6'b000010,
    WQ   = 6'b000100,
    SCEN = 6'b001000,
    CCR  = 6'b010000,
    WFCR = 6'b100000
  } state_e;

  logic [4:0] raw, sync1_d, sync1_q, sync2_d, sync2_q;
  logic [4:0] scen_vec, dpb_vec;

  assign raw = {BtnL, BtnR, BtnU, BtnD, BtnC};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_btn
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          sync_b, fire, scen_d, scen_q, dpb_d, dpb_q;

    assign sync_b  = sync2_q[i];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ARM:
          if (sync_b)               cnt_d = '0;
          else if (cnt_q == DB_LAST) begin state_d = INI; cnt_d = '0; end
          else                      cnt_d = cnt_inc;
        INI:
          if (sync_b) begin state_d = WQ; cnt_d = '0; end
        WQ:
          if (!sync_b)              begin state_d = INI;  cnt_d = '0; end
          else if (cnt_q == DB_LAST) begin state_d = SCEN; cnt_d = '0; end
          else                      cnt_d = cnt_inc;
        SCEN:
          state_d = CCR;
        CCR:
          if (!sync_b) begin state_d = WFCR; cnt_d = '0; end
        WFCR:
          if (sync_b)               begin state_d = CCR; cnt_d = '0; end
          else if (cnt_q == DB_LAST) begin state_d = INI; cnt_d = '0; end
          else                      cnt_d = cnt_inc;
        default: begin
          state_d = ARM;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
      scen_d = (state_d == SCEN) || fire;
      dpb_d  = state_d inside {SCEN, CCR, WFCR};
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state_q <= ARM;
        cnt_q   <= '0;
        scen_q  <= 1'b0;
        dpb_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        scen_q  <= scen_d;
        dpb_q   <= dpb_d;
      end
    end

    assign scen_vec[i] = scen_q;
    assign dpb_vec[i]  = dpb_q;

`ifdef BTN_AUTO_REPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rpt
      logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
      logic          rpt_first_q, rpt_first_d, rpt_fire;

      // Timer runs only while held in CCR; any other cycle restarts the initial delay.
      always_comb begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
        rpt_fire    = 1'b0;
        if (state_q == CCR && sync_b) begin
          rpt_first_d = rpt_first_q;
          if (rpt_cnt_q == (rpt_first_q ? RATE_LAST : DELAY_LAST)) begin
            rpt_fire    = 1'b1;
            rpt_first_d = 1'b1;
          end else begin
            rpt_cnt_d = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          rpt_cnt_q   <= '0;
          rpt_first_q <= 1'b0;
        end else begin
          rpt_cnt_q   <= rpt_cnt_d;
          rpt_first_q <= rpt_first_d;
        end
      end

      assign fire = rpt_fire;
    end else begin : g_no_rpt
      assign fire = 1'b0;
    end
`else
    assign fire = 1'b0;
`endif
  end

  assign {BtnL_SCEN, BtnR_SCEN, BtnU_SCEN, BtnD_SCEN, BtnC_SCEN} = scen_vec;
  assign Btn_DPB = dpb_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed timing cases plus random bouncing stimulus against a run-length model.
module tb_btn_conditioner;

  localparam int D  = 8;
  localparam int RD = 40;
  localparam int RR = 16;
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [4:0] RPT_MASK = 5'b01010;
  localparam bit         RPT_ON   = 1'b1;
`else
  localparam logic [4:0] RPT_MASK = 5'b00000;
  localparam bit         RPT_ON   = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] btn = '0;
  logic       BtnL_SCEN, BtnR_SCEN, BtnU_SCEN, BtnD_SCEN, BtnC_SCEN;
  logic [4:0] Btn_DPB;
  logic [4:0] scen, dpb;

  assign scen = {BtnL_SCEN, BtnR_SCEN, BtnU_SCEN, BtnD_SCEN, BtnC_SCEN};
  assign dpb  = Btn_DPB;

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnL(btn[4]), .BtnR(btn[3]), .BtnU(btn[2]), .BtnD(btn[1]), .BtnC(btn[0]),
    .BtnL_SCEN(BtnL_SCEN), .BtnR_SCEN(BtnR_SCEN), .BtnU_SCEN(BtnU_SCEN),
    .BtnD_SCEN(BtnD_SCEN), .BtnC_SCEN(BtnC_SCEN), .Btn_DPB(Btn_DPB)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: button level described by run lengths of the synchronized input.
  logic [4:0] r1, r2, s_vec, exp_scen, exp_dpb;
  bit m_ready[5], m_db[5], m_settle[5], m_lowflag[5];
  int m_hi[5], m_lo[5], m_rel[5], m_hold[5];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r1 = '0; r2 = '0; exp_scen = '0; exp_dpb = '0;
      for (int i = 0; i < 5; i++) begin
        m_ready[i] = 0; m_db[i] = 0; m_settle[i] = 0; m_lowflag[i] = 0;
        m_hi[i] = 0; m_lo[i] = 0; m_rel[i] = 0; m_hold[i] = 0;
      end
    end else begin
      s_vec = r2;
      r2 = r1;
      r1 = btn;
      for (int i = 0; i < 5; i++) begin
        exp_scen[i] = 1'b0;
        if (!m_db[i]) begin
          if (s_vec[i]) begin m_hi[i]++; m_lo[i] = 0; end
          else          begin m_lo[i]++; m_hi[i] = 0; end
          if (!m_ready[i]) begin
            if (m_lo[i] >= D) m_ready[i] = 1;
          end else if (m_hi[i] == D + 1) begin
            m_db[i] = 1; exp_scen[i] = 1'b1; m_settle[i] = 1;
            m_rel[i] = 0; m_hold[i] = 0; m_lowflag[i] = 0;
          end
        end else if (m_settle[i]) begin
          m_settle[i] = 0;
        end else if (!s_vec[i]) begin
          m_rel[i]++; m_hold[i] = 0; m_lowflag[i] = 1;
          if (m_rel[i] == D + 1) begin
            m_db[i] = 0; m_ready[i] = 1; m_hi[i] = 0; m_lo[i] = 0;
          end
        end else begin
          m_rel[i] = 0;
          if (m_lowflag[i]) m_lowflag[i] = 0;
          else begin
            m_hold[i]++;
            if (RPT_MASK[i] && (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RR == 0)))
              exp_scen[i] = 1'b1;
          end
        end
        exp_dpb[i] = m_db[i];
      end
    end
  end

  always begin
    @(posedge Clk);
    #1;
    check("cycle_scen", scen, exp_scen);
    check("cycle_dpb", dpb, exp_dpb);
  end

  logic [4:0] scen_log[$];
  logic [4:0] dpb_log[$];
  int offs[$];

  task automatic run_watch(input int n);
    scen_log.delete();
    dpb_log.delete();
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
      scen_log.push_back(scen);
      dpb_log.push_back(dpb);
    end
  endtask

  task automatic find_offs(input int idx);
    offs.delete();
    for (int k = 0; k < scen_log.size(); k++)
      if (scen_log[k][idx]) offs.push_back(k);
  endtask

  function automatic int first_off();
    return (offs.size() > 0) ? offs[0] : -1;
  endfunction

  int rem[5];
  int bounce_pulses;
  int rpt_exp[6] = '{10, 51, 67, 83, 99, 115};

  initial begin
    repeat (3) @(negedge Clk);
    check("reset_scen", scen, 5'b0);
    check("reset_dpb", dpb, 5'b0);
    @(negedge Clk); Reset = 1'b0;
    run_watch(12);

    // Clean press on U
    @(negedge Clk); btn[2] = 1'b1;
    run_watch(100);
    find_offs(2);
    check("u_pulse_count", offs.size(), 1);
    check("u_pulse_offset", first_off(), 10);
    check("u_dpb_before", dpb_log[9][2], 1'b0);
    check("u_dpb_held", dpb_log[99][2], 1'b1);
    @(negedge Clk); btn[2] = 1'b0;
    run_watch(20);
    find_offs(2);
    check("u_release_no_pulse", offs.size(), 0);
    check("u_dpb_release_hold", dpb_log[9][2], 1'b1);
    check("u_dpb_release_low", dpb_log[10][2], 1'b0);

    // Bouncing press on C
    bounce_pulses = 0;
    for (int b = 0; b < 4; b++) begin
      @(negedge Clk); btn[0] = 1'b1;
      run_watch(5); find_offs(0); bounce_pulses += offs.size();
      @(negedge Clk); btn[0] = 1'b0;
      run_watch(2); find_offs(0); bounce_pulses += offs.size();
    end
    check("c_bounce_no_pulse", bounce_pulses, 0);
    @(negedge Clk); btn[0] = 1'b1;
    run_watch(20);
    find_offs(0);
    check("c_pulse_count", offs.size(), 1);
    check("c_pulse_offset", first_off(), 10);
    @(negedge Clk); btn[0] = 1'b0;
    run_watch(20);

    // Simultaneous L and D
    @(negedge Clk); btn[4] = 1'b1; btn[1] = 1'b1;
    run_watch(30);
    find_offs(4);
    check("l_pulse_count", offs.size(), 1);
    check("l_pulse_offset", first_off(), 10);
    find_offs(1);
    check("d_pulse_count", offs.size(), 1);
    check("d_pulse_offset", first_off(), 10);
    @(negedge Clk); btn[4] = 1'b0; btn[1] = 1'b0;
    run_watch(20);

    // Reset in the middle of an R press
    @(negedge Clk); btn[3] = 1'b1;
    run_watch(7);
    find_offs(3);
    check("r_pre_reset_no_pulse", offs.size(), 0);
    @(negedge Clk); Reset = 1'b1;
    run_watch(2);
    @(negedge Clk); Reset = 1'b0;
    run_watch(30);
    find_offs(3);
    check("r_held_after_reset_no_pulse", offs.size(), 0);
    @(negedge Clk); btn[3] = 1'b0;
    run_watch(8);
    @(negedge Clk); btn[3] = 1'b1;
    run_watch(30);
    find_offs(3);
    check("r_repress_count", offs.size(), 1);
    check("r_repress_offset", first_off(), 10);
    @(negedge Clk); btn[3] = 1'b0;
    run_watch(20);

    // Long hold on D
    @(negedge Clk); btn[1] = 1'b1;
    run_watch(120);
    find_offs(1);
    if (RPT_ON) begin
      check("d_hold_count", offs.size(), 6);
      for (int k = 0; k < 6; k++)
        check($sformatf("d_hold_offset%0d", k), (k < offs.size()) ? offs[k] : -1, rpt_exp[k]);
    end else begin
      check("d_hold_count", offs.size(), 1);
      check("d_hold_offset", first_off(), 10);
    end
    @(negedge Clk); btn[1] = 1'b0;
    run_watch(30);
    find_offs(1);
    check("d_release_no_pulse", offs.size(), 0);

    // Random bouncing on all buttons with occasional resets
    for (int b = 0; b < 5; b++) rem[b] = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 1499) == 0);
      for (int b = 0; b < 5; b++) begin
        if (rem[b] == 0) begin
          btn[b] = ~btn[b];
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(9, 90);
        end else begin
          rem[b]--;
        end
      end
    end
    @(negedge Clk); Reset = 1'b0; btn = '0;
    run_watch(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
